// File: rtl/lsr_shift_ctrl.sv
// Sequencer for a PIPO left-shift register: loads a latched word, applies N
// fill-bit shifts, then captures and returns the register's parallel output.
module lsr_shift_ctrl #(
  parameter int BITS  = 4,
  parameter int CNT_W = 3
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [BITS-1:0] in_data,
  input  logic [CNT_W-1:0] in_shift,
  input  logic            in_fill,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [BITS-1:0] lsr_data,
  output logic            lsr_load,
  output logic            lsr_in,
  input  logic [BITS-1:0] lsr_out,
  output logic [BITS-1:0] res_data,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            busy
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(BITS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    HOLD    = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [BITS-1:0] word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            fill_q, fill_d;
  logic [BITS-1:0] res_q, res_d;
  logic            rvld_q, rvld_d;

  // Counts above the register width only ever produce an all-fill result.
  logic [CNT_W-1:0] shift_clamped;
  assign shift_clamped = (in_shift > MAX_CNT) ? MAX_CNT : in_shift;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
      res_q   <= '0;
      rvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      res_q   <= res_d;
      rvld_q  <= rvld_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    cnt_d    = cnt_q;
    fill_d   = fill_q;
    res_d    = res_q;
    rvld_d   = rvld_q;
    in_ready = 1'b0;
    lsr_load = 1'b0;
    lsr_in   = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_d  = in_data;
          fill_d  = in_fill;
          cnt_d   = shift_clamped;
          state_d = LOAD;
        end
      end
      LOAD: begin
        lsr_load = 1'b1;
        state_d  = (cnt_q != '0) ? SHIFT : CAPTURE;
      end
      SHIFT: begin
        // The register shifts on every edge with Load low, so leaving on
        // count==1 yields exactly N shift edges.
        lsr_in = fill_q;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = CAPTURE;
      end
      CAPTURE: begin
        res_d   = lsr_out;
        rvld_d  = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          rvld_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign lsr_data  = word_q;
  assign res_data  = res_q;
  assign res_valid = rvld_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/lsr_shift_ctrl.md
Name: lsr_shift_ctrl

Overview:
Upstream sequencer for the parameterised PIPO left-shift register (ports data/CLK/RST/Load/In/out).
- Accepts a parallel word, a shift count and a fill bit over a valid/ready handshake.
- Drives the shift register's data, Load and In pins, and times exactly N shift cycles.
- Captures the register's parallel output and returns it on a second valid/ready handshake.

Parameters:
- BITS, 4: word width; must match the attached shift register.
- CNT_W, 3: width of the shift-count field; must be at least clog2(BITS+1).

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous reset, active-high.
- in_data  input  BITS  word to load.
- in_shift  input  CNT_W  number of shifts N to apply.
- in_fill  input  1  bit shifted into the LSB on each shift.
- in_valid  input  1  request valid.
- in_ready  output  1  high only in IDLE.
- lsr_data  output  BITS  to the shift register's data pin; holds the latched word.
- lsr_load  output  1  to the shift register's Load pin.
- lsr_in  output  1  to the shift register's In pin.
- lsr_out  input  BITS  from the shift register's out pin.
- res_data  output  BITS  captured result.
- res_valid  output  1  result valid.
- res_ready  input  1  result accepted.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Attached register model: on each edge it loads data when Load=1; otherwise it shifts left by one and inserts In at the LSB. It shifts every cycle Load=0; there is no enable.
- States: IDLE, LOAD, SHIFT, CAPTURE, HOLD. The state is registered; in_ready, busy and lsr_load decode from it.
- Reset (RST=1 at an edge):
  - state=IDLE; word, count, fill and res_data registers cleared to 0; res_valid=0.
  - Outputs after the reset edge: in_ready=1, busy=0, lsr_load=0, lsr_in=0, lsr_data=0, res_data=0, res_valid=0.
  - Reset mid-operation aborts immediately. Any pending result is discarded, with no res_valid pulse.
- IDLE:
  - in_ready=1.
  - On in_valid=1, latch in_data, in_fill and N=min(in_shift, BITS), then go to LOAD.
  - Otherwise stay in IDLE. in_data and in_shift are ignored when in_valid=0.
- LOAD:
  - lsr_load=1 for exactly one cycle; the register loads the latched word at this edge.
  - Go to SHIFT if N>0, else go to CAPTURE.
- SHIFT:
  - lsr_load=0 and lsr_in=fill.
  - The counter starts at N and decrements each cycle.
  - Go to CAPTURE in the cycle the counter reaches 1. This gives exactly N shift edges.
- CAPTURE:
  - lsr_load=0 and lsr_in=0.
  - At this edge, res_data<=lsr_out, which equals ((word<<N) | fill-replicated low N bits) truncated to BITS. Also res_valid<=1.
  - The shift register shifts once more at this edge; that shift is don't-care.
  - Go to HOLD.
- HOLD:
  - res_valid=1 and res_data stable until res_ready=1 at an edge; then res_valid<=0 and go to IDLE.
  - res_ready is ignored outside HOLD.
- lsr_in is 0 in every state except SHIFT.
- lsr_data holds the latched word from acceptance until the next acceptance.
- Latency: acceptance edge to res_valid rising is N+3 edges (LOAD 1, SHIFT N, CAPTURE 1, plus the acceptance edge). For N=0 it is 3 edges.
- Back-to-back: the earliest next acceptance is the cycle after the HOLD handshake; in_ready returns 1 in that cycle.
- A count above BITS clamps to BITS; the result is then all fill bits.

Test Plan:
- Reset with RST=1 for 2 cycles, in_valid=1 held -> no acceptance; after release in_ready=1, busy=0, res_valid=0, lsr_load=0.
- in_data=1001, N=1, fill=0, res_ready=1 -> lsr_load high exactly 1 cycle; res_data=0010, res_valid 4 edges after acceptance.
- in_data=1001, N=2, fill=1 -> lsr_in=1 for exactly 2 cycles; res_data=0111.
- in_data=1011, N=0 -> res_data=1011 after 3 edges; N=7 (clamped to 4), fill=1 -> res_data=1111; N=4, fill=0 -> 0000.
- res_ready=0 for 5 cycles in HOLD -> res_valid and res_data stable, in_ready=0; in_valid pulses meanwhile are ignored; in_ready=1 the cycle after res_ready=1.
- RST asserted during SHIFT (in_data=1001, N=3) -> next cycle IDLE, res_valid=0, lsr_in=0; a following request (0110, N=1, fill=1) gives res_data=1101.
